// File: rtl/wdecoder.sv
// Receive side of the weight-sum byte link: resynchronises on the 0x55/0x66 header,
// rebuilds the 16-bit block sum and keeps saturating frame/error statistics.
module wdecoder #(
    parameter int          SUM_SIZE    = 16,
    parameter logic [7:0]  HDR0        = 8'h55,
    parameter logic [7:0]  HDR1        = 8'h66,
    parameter int          SYNC_STAGES = 2,
    parameter int          TIMEOUT     = 255,
    parameter int          CNT_SIZE    = 16
) (
    input  logic                dclk,
    input  logic                rst_n,
    input  logic                ready,
    input  logic [7:0]          din,
    output logic [SUM_SIZE-1:0] sum_out,
    output logic                sum_valid,
    output logic                locked,
    output logic [CNT_SIZE-1:0] frame_cnt,
    output logic [CNT_SIZE-1:0] err_cnt
);

    localparam int SW = 9 * SYNC_STAGES;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {HUNT0, HUNT1, DHI, DLO} state_t;

    // {ready, din} travel together so the byte is taken from the same stage as the strobe
    logic [SW-1:0]          sync_q;
    logic [SYNC_STAGES-1:0] fill;
    logic                   sync_ready;
    logic [7:0]             sync_din;
    logic                   ready_d;
    logic                   armed;
    logic                   byte_stb;
    logic [7:0]             byte_q;

    assign sync_ready = sync_q[SW-1];
    assign sync_din   = sync_q[SW-2 -: 8];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            fill     <= '0;
            ready_d  <= 1'b0;
            armed    <= 1'b0;
            byte_stb <= 1'b0;
            byte_q   <= '0;
        end else begin
            sync_q   <= SW'({sync_q, ready, din});
            fill     <= SYNC_STAGES'({fill, 1'b1});
            ready_d  <= sync_ready;
            // A ready already high at reset release must first be seen low before it can strobe
            if (fill[SYNC_STAGES-1] && !sync_ready)
                armed <= 1'b1;
            byte_stb <= armed & sync_ready & ~ready_d;
            byte_q   <= sync_din;
        end
    end

    state_t                state, state_n;
    logic [7:0]            hi, hi_n;
    logic [TW-1:0]         timer, timer_n;
    logic [SUM_SIZE-1:0]   sum_n;
    logic                  valid_n, locked_n, frame_inc, err_inc;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_n   = state;
        hi_n      = hi;
        sum_n     = sum_out;
        valid_n   = 1'b0;
        locked_n  = locked;
        frame_inc = 1'b0;
        err_inc   = 1'b0;
        if (byte_stb) begin
            unique case (state)
                HUNT0: if (byte_q == HDR0) state_n = HUNT1;
                HUNT1: begin
                    if (byte_q == HDR1) begin
                        state_n = DHI;
                    end else if (byte_q != HDR0) begin
                        state_n  = HUNT0;
                        err_inc  = 1'b1;
                        locked_n = 1'b0;
                    end
                end
                DHI: begin
                    hi_n    = byte_q;
                    state_n = DLO;
                end
                DLO: begin
                    sum_n     = SUM_SIZE'({hi, byte_q});
                    valid_n   = 1'b1;
                    frame_inc = 1'b1;
                    locked_n  = 1'b1;
                    state_n   = HUNT0;
                end
                default: state_n = HUNT0;
            endcase
        end else if (state != HUNT0 && timer == TW'(TIMEOUT)) begin
            state_n  = HUNT0;
            err_inc  = 1'b1;
            locked_n = 1'b0;
        end
        timer_n = (byte_stb || state_n == HUNT0) ? '0 : timer + 1'b1;
    end

    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT0;
            hi        <= '0;
            timer     <= '0;
            sum_out   <= '0;
            sum_valid <= 1'b0;
            locked    <= 1'b0;
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            state     <= state_n;
            hi        <= hi_n;
            timer     <= timer_n;
            sum_out   <= sum_n;
            sum_valid <= valid_n;
            locked    <= locked_n;
            if (frame_inc && frame_cnt != '1)
                frame_cnt <= frame_cnt + 1'b1;
            if (err_inc && err_cnt != '1)
                err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_wdecoder.sv
// Scoreboard bench for wdecoder: expected sums are queued as frames are sent
// and compared whenever sum_valid is seen.
module tb_wdecoder;

    localparam int CNT  = 3;
    localparam int SYNC = 2;
    localparam int TMO  = 255;

    logic            dclk  = 1'b0;
    logic            rst_n = 1'b0;
    logic            ready = 1'b0;
    logic [7:0]      din   = 8'h00;
    logic [15:0]     sum_out;
    logic            sum_valid;
    logic            locked;
    logic [CNT-1:0]  frame_cnt;
    logic [CNT-1:0]  err_cnt;

    int          checks = 0;
    int          errors = 0;
    int          vcount = 0;
    int          hold   = 3;
    int          lat;
    logic [15:0] exp_q[$];

    wdecoder #(
        .SUM_SIZE(16), .HDR0(8'h55), .HDR1(8'h66),
        .SYNC_STAGES(SYNC), .TIMEOUT(TMO), .CNT_SIZE(CNT)
    ) dut (
        .dclk(dclk), .rst_n(rst_n), .ready(ready), .din(din),
        .sum_out(sum_out), .sum_valid(sum_valid), .locked(locked),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    always #5 dclk = ~dclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    always @(negedge dclk) begin
        if (rst_n && sum_valid) begin
            vcount++;
            if (exp_q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
            else                   check("sum_out", {16'h0, sum_out}, {16'h0, exp_q.pop_front()});
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge dclk); #1;
        din   = b;
        ready = 1'b1;
        repeat (hold) @(posedge dclk);
        #1 ready = 1'b0;
        repeat (4) @(posedge dclk);
    endtask

    task automatic send_frame(input logic [7:0] hi, input logic [7:0] lo);
        exp_q.push_back({hi, lo});
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(hi);
        send_byte(lo);
    endtask

    task automatic settle();
        repeat (8) @(posedge dclk);
        #1 check("sb_empty", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge dclk); #1 rst_n = 1'b0;
        #2;
        check("rst_sum", sum_out, 0);
        check("rst_valid", sum_valid, 0);
        check("rst_locked", locked, 0);
        check("rst_frame", frame_cnt, 0);
        check("rst_err", err_cnt, 0);
        exp_q.delete();
        vcount = 0;
        repeat (2) @(posedge dclk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        do_reset();

        // Plain frame, with latency from raw ready rise of SUM_LO to sum_valid
        exp_q.push_back(16'h1234);
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h12);
        @(posedge dclk); #1;
        din   = 8'h34;
        ready = 1'b1;
        lat   = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge dclk); #1;
            if (sum_valid && lat == 0) lat = i;
        end
        ready = 1'b0;
        check("latency", lat, SYNC + 2);
        settle();
        check("t1_pulses", vcount, 1);
        check("t1_frame", frame_cnt, 1);
        check("t1_locked", locked, 1);
        check("t1_err", err_cnt, 0);

        // Garbage and repeated header start
        do_reset();
        exp_q.push_back(16'h00FF);
        send_byte(8'hAA);
        send_byte(8'h55);
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h00);
        send_byte(8'hFF);
        settle();
        check("t2_sum", sum_out, 16'h00FF);
        check("t2_frame", frame_cnt, 1);
        check("t2_err", err_cnt, 0);

        // Header mismatch
        do_reset();
        send_byte(8'h55);
        send_byte(8'h77);
        check("t3_err", err_cnt, 1);
        check("t3_unlocked", locked, 0);
        send_frame(8'hAB, 8'hCD);
        settle();
        check("t3_sum", sum_out, 16'hABCD);
        check("t3_locked", locked, 1);

        // Timeout inside a frame drops the partial frame
        do_reset();
        send_frame(8'h11, 8'h22);
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h01);
        repeat (TMO + 20) @(posedge dclk);
        #1;
        check("t4_err", err_cnt, 1);
        check("t4_unlocked", locked, 0);
        send_byte(8'h02);
        send_frame(8'h00, 8'h02);
        settle();
        check("t4_sum", sum_out, 16'h0002);
        check("t4_frame", frame_cnt, 2);
        check("t4_err_final", err_cnt, 1);

        // Header values inside the payload
        do_reset();
        send_frame(8'h55, 8'h66);
        settle();
        check("t5_sum", sum_out, 16'h5566);
        check("t5_frame", frame_cnt, 1);
        check("t5_err", err_cnt, 0);

        // Reset mid-frame
        do_reset();
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h12);
        do_reset();
        send_byte(8'h34);
        send_frame(8'h00, 8'h01);
        settle();
        check("t6_sum", sum_out, 16'h0001);
        check("t6_frame", frame_cnt, 1);

        // Ready already high at reset release is not a byte
        @(posedge dclk); #1;
        din   = 8'h55;
        ready = 1'b1;
        do_reset();
        repeat (6) @(posedge dclk);
        #1 ready = 1'b0;
        repeat (4) @(posedge dclk);
        send_byte(8'h66);
        send_byte(8'h00);
        send_byte(8'h07);
        settle();
        check("t6b_frame", frame_cnt, 0);
        check("t6b_pulses", vcount, 0);

        // Long ready pulses and counter saturation
        do_reset();
        hold = 10;
        for (int i = 0; i < 6; i++) send_frame(8'(i + 1), 8'h5A);
        settle();
        check("t7_frame_pre", frame_cnt, 6);
        send_frame(8'hC3, 8'h3C);
        send_frame(8'hE1, 8'h1E);
        settle();
        check("t7_frame_sat", frame_cnt, 7);
        check("t7_locked", locked, 1);
        hold = 3;
        for (int i = 0; i < 8; i++) begin
            send_byte(8'h55);
            send_byte(8'h77);
        end
        #1;
        check("t7_err_sat", err_cnt, 7);
        check("t7_unlocked", locked, 0);
        check("t7_frame_hold", frame_cnt, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
